// File: rtl/uart_tx.sv
// Byte-wide UART transmitter: start, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Ports: clk_i, rst_n (sync, active-low), valid/data/ready handshake in, busy/done status, uart_txdata serial out.
module uart_tx #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int UART_BPS  = 115200,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic       uart_tx_valid,
  input  logic [7:0] uart_tx_data,
  output logic       uart_tx_ready,
  output logic       uart_tx_busy,
  output logic       uart_tx_done,
  output logic       uart_txdata
);

  localparam int          BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam logic [15:0] BAUD_LAST    = 16'(BAUD_CNT_MAX - 1);
  localparam logic        STOP_LAST    = (STOP_BITS == 2);
  localparam logic        PAR_EN       = (PARITY != 0);
  localparam logic        PAR_ODD      = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t      r_state;
  logic [15:0] r_baud_cnt;
  logic [2:0]  r_bit_cnt;
  logic        r_stop_cnt;
  logic [7:0]  r_data;
  logic        r_txd;
  logic        r_done;

  state_t      w_state_nxt;
  logic [15:0] w_baud_nxt;
  logic [2:0]  w_bit_nxt;
  logic        w_stop_nxt;
  logic [7:0]  w_data_nxt;
  logic        w_txd_nxt;
  logic        w_done_nxt;
  logic        w_baud_end;
  logic [2:0]  w_bit_inc;
  logic        w_par;

  assign w_baud_end = (r_baud_cnt == BAUD_LAST);
  assign w_bit_inc  = r_bit_cnt + 3'd1;
  // Odd mode inverts so the total ones count (parity included) is odd.
  assign w_par      = PAR_ODD ? ~^r_data : ^r_data;

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_data     <= '0;
      r_txd      <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_stop_cnt <= w_stop_nxt;
      r_data     <= w_data_nxt;
      r_txd      <= w_txd_nxt;
      r_done     <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_stop_nxt  = r_stop_cnt;
    w_data_nxt  = r_data;
    w_txd_nxt   = r_txd;
    w_done_nxt  = 1'b0;
    if (r_state != S_IDLE) begin
      w_baud_nxt = w_baud_end ? 16'd0 : r_baud_cnt + 16'd1;
    end
    unique case (r_state)
      S_IDLE: begin
        w_txd_nxt = 1'b1;
        if (uart_tx_valid) begin
          w_data_nxt  = uart_tx_data;
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_stop_nxt  = 1'b0;
          w_state_nxt = S_START;
          w_txd_nxt   = 1'b0;
        end
      end
      S_START: begin
        if (w_baud_end) begin
          w_state_nxt = S_DATA;
          w_bit_nxt   = '0;
          w_txd_nxt   = r_data[0];
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = PAR_EN ? S_PARITY : S_STOP;
            w_txd_nxt   = PAR_EN ? w_par : 1'b1;
          end else begin
            w_bit_nxt = w_bit_inc;
            w_txd_nxt = r_data[w_bit_inc];
          end
        end
      end
      S_PARITY: begin
        if (w_baud_end) begin
          w_state_nxt = S_STOP;
          w_txd_nxt   = 1'b1;
        end
      end
      S_STOP: begin
        w_txd_nxt = 1'b1;
        if (w_baud_end) begin
          if (r_stop_cnt == STOP_LAST) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_stop_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_txd_nxt   = 1'b1;
      end
    endcase
  end

  assign uart_tx_busy  = (r_state != S_IDLE);
  assign uart_tx_ready = !uart_tx_busy;
  assign uart_tx_done  = r_done;
  assign uart_txdata   = r_txd;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances cover parity/stop-bit variants.
// Checks every cycle of each frame on the line, busy, ready and done.
module tb_uart_tx;

  logic       clk_i;
  logic       rst_n;
  logic [7:0] uart_tx_data;
  logic       vld [4];
  logic       rdy [4];
  logic       bsy [4];
  logic       dn  [4];
  logic       txd [4];

  int n_checks;
  int n_fail;

  uart_tx #(.CLK_FREQ(1_000_000), .UART_BPS(100_000),
            .PARITY(0), .STOP_BITS(1)) u0 (
    .clk_i(clk_i), .rst_n(rst_n),
    .uart_tx_valid(vld[0]), .uart_tx_data(uart_tx_data),
    .uart_tx_ready(rdy[0]), .uart_tx_busy(bsy[0]),
    .uart_tx_done(dn[0]), .uart_txdata(txd[0]));

  uart_tx #(.CLK_FREQ(1_000_000), .UART_BPS(100_000),
            .PARITY(2), .STOP_BITS(1)) u1 (
    .clk_i(clk_i), .rst_n(rst_n),
    .uart_tx_valid(vld[1]), .uart_tx_data(uart_tx_data),
    .uart_tx_ready(rdy[1]), .uart_tx_busy(bsy[1]),
    .uart_tx_done(dn[1]), .uart_txdata(txd[1]));

  uart_tx #(.CLK_FREQ(1_000_000), .UART_BPS(100_000),
            .PARITY(1), .STOP_BITS(1)) u2 (
    .clk_i(clk_i), .rst_n(rst_n),
    .uart_tx_valid(vld[2]), .uart_tx_data(uart_tx_data),
    .uart_tx_ready(rdy[2]), .uart_tx_busy(bsy[2]),
    .uart_tx_done(dn[2]), .uart_txdata(txd[2]));

  uart_tx #(.CLK_FREQ(1_000_000), .UART_BPS(100_000),
            .PARITY(1), .STOP_BITS(2)) u3 (
    .clk_i(clk_i), .rst_n(rst_n),
    .uart_tx_valid(vld[3]), .uart_tx_data(uart_tx_data),
    .uart_tx_ready(rdy[3]), .uart_tx_busy(bsy[3]),
    .uart_tx_done(dn[3]), .uart_txdata(txd[3]));

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(string tag, logic obs, logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b t=%0t",
             tag, obs, exp, $time);
    end
  endtask

  task automatic chk_idle(int idx, string tag);
    chk({tag, "_line"}, txd[idx], 1'b1);
    chk({tag, "_ready"}, rdy[idx], 1'b1);
    chk({tag, "_busy"}, bsy[idx], 1'b0);
    chk({tag, "_done"}, dn[idx], 1'b0);
  endtask

  // n negedges of idle-line checks
  task automatic idle_check(int idx, int n, string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      chk_idle(idx, tag);
    end
  endtask

  // Caller sits at a negedge with vld[idx] high. bits[k] is the
  // expected line level for bit k (start at bit 0). Ends at the
  // negedge following edge T + nb*10, unless aborted by reset.
  task automatic frame(int idx, string tag, logic [11:0] bits,
                       int nb, bit hold, bit noise, int abort,
                       logic [7:0] nxt);
    logic exp_line;
    @(posedge clk_i);
    @(negedge clk_i);
    if (!hold) vld[idx] = 1'b0;
    uart_tx_data = nxt;
    for (int c = 0; c <= nb * 10; c++) begin
      exp_line = (c < nb * 10) ? bits[c / 10] : 1'b1;
      chk({tag, "_line"}, txd[idx], exp_line);
      chk({tag, "_busy"}, bsy[idx], c < nb * 10);
      chk({tag, "_ready"}, rdy[idx], c >= nb * 10);
      chk({tag, "_done"}, dn[idx], c == nb * 10);
      if (c == abort) begin
        rst_n = 1'b0;
        return;
      end
      if (c < nb * 10) begin
        if (noise) begin
          uart_tx_data = c[0] ? 8'h81 : 8'h7E;
          vld[idx] = (c == 30);
        end
        @(negedge clk_i);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    uart_tx_data = 8'h00;
    for (int i = 0; i < 4; i++) vld[i] = 1'b0;

    // 1: reset state, held until first valid
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    for (int i = 0; i < 4; i++) chk_idle(i, "rst");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) idle_check(i, 3, "post_rst");

    // 2: 0xA5, no parity, 1 stop
    uart_tx_data = 8'hA5;
    vld[0] = 1'b1;
    frame(0, "a5", {3'b001, 8'hA5, 1'b0}, 10, 0, 0, -1, 8'h00);
    idle_check(0, 3, "a5_after");

    // 3: held valid, 0x00 then 0xFF one idle clock apart
    uart_tx_data = 8'h00;
    vld[0] = 1'b1;
    frame(0, "b2b0", {3'b001, 8'h00, 1'b0}, 10, 1, 0, -1, 8'hFF);
    frame(0, "b2b1", {3'b001, 8'hFF, 1'b0}, 10, 0, 0, -1, 8'hFF);
    idle_check(0, 3, "b2b_after");

    // 4: parity variants with 0x07 (three ones)
    uart_tx_data = 8'h07;
    vld[1] = 1'b1;
    frame(1, "even07", {2'b01, 1'b1, 8'h07, 1'b0}, 11, 0, 0, -1, 8'h00);
    idle_check(1, 2, "even_after");
    uart_tx_data = 8'h07;
    vld[2] = 1'b1;
    frame(2, "odd07", {2'b01, 1'b0, 8'h07, 1'b0}, 11, 0, 0, -1, 8'h00);
    idle_check(2, 2, "odd_after");
    uart_tx_data = 8'h07;
    vld[3] = 1'b1;
    frame(3, "odd2s", {2'b11, 1'b0, 8'h07, 1'b0}, 12, 0, 0, -1, 8'h00);
    idle_check(3, 2, "odd2s_after");

    // 5: valid pulse and data noise during a 0x3C frame
    uart_tx_data = 8'h3C;
    vld[0] = 1'b1;
    frame(0, "noise", {3'b001, 8'h3C, 1'b0}, 10, 0, 1, -1, 8'h81);
    vld[0] = 1'b0;
    idle_check(0, 25, "noise_after");

    // 6: reset during data bit 3 of 0x5A, then 0xC3
    uart_tx_data = 8'h5A;
    vld[0] = 1'b1;
    frame(0, "abort", {3'b001, 8'h5A, 1'b0}, 10, 0, 0, 43, 8'h00);
    @(negedge clk_i);
    chk_idle(0, "abort_rst");
    rst_n = 1'b1;
    idle_check(0, 12, "abort_after");
    uart_tx_data = 8'hC3;
    vld[0] = 1'b1;
    frame(0, "c3", {3'b001, 8'hC3, 1'b0}, 10, 0, 0, -1, 8'h00);
    idle_check(0, 3, "c3_after");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
